// File: rtl/midi_note_tracker.sv
// MIDI serial receiver and Note-On/Off parser feeding a last-note-priority stack
// of held keys; top entry drives note_out/vel_out for the display/synth logic.
module midi_note_tracker #(
    parameter int         CLKS_PER_BIT = 128,
    parameter int         MAX_NOTES    = 4,
    parameter bit         CHAN_FILT_EN = 1'b0,
    parameter logic [3:0] CHANNEL      = 4'd0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             midi_in,
    output logic [6:0]                       note_out,
    output logic [6:0]                       vel_out,
    output logic                             note_active,
    output logic [$clog2(MAX_NOTES+1)-1:0]   held_count,
    output logic                             event_valid,
    output logic                             event_on,
    output logic                             framing_err
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(MAX_NOTES + 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT} uart_state_t;

    logic           sync_p0, sync_p1;
    logic           rx;
    uart_state_t    state;
    logic [TW-1:0]  timer;
    logic [3:0]     bit_cnt;
    logic [7:0]     shreg;
    logic           byte_ok;
    logic           rs_valid, rs_on, expect_vel;
    logic [6:0]     key_p0;
    logic           chan_ok, ev_fire, ev_is_on;
    logic [6:0]     keys   [MAX_NOTES];
    logic [6:0]     vels   [MAX_NOTES];
    logic [6:0]     keys_n [MAX_NOTES];
    logic [6:0]     vels_n [MAX_NOTES];
    logic [CW-1:0]  count, count_n;
    logic           hit;
    int             hit_idx, lim;

    // Stage: input synchroniser
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= midi_in;
            sync_p1 <= sync_p0;
        end
    end
    assign rx = sync_p1;

    // Stage: UART framing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            bit_cnt     <= '0;
            byte_ok     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            byte_ok     <= 1'b0;
            framing_err <= 1'b0;
            case (state)
                S_IDLE: if (!rx) begin
                    state   <= S_START;
                    timer   <= '0;
                    bit_cnt <= '0;
                end
                S_START: if (timer == T_HALF) begin
                    timer   <= '0;
                    bit_cnt <= '0;
                    state   <= rx ? S_IDLE : S_DATA;
                end else timer <= timer + 1'b1;
                S_DATA: if (timer == T_FULL) begin
                    timer <= '0;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt <= '0;
                        state   <= S_STOP;
                    end else bit_cnt <= bit_cnt + 1'b1;
                end else timer <= timer + 1'b1;
                S_STOP: if (timer == T_FULL) begin
                    timer   <= '0;
                    bit_cnt <= '0;
                    if (rx) begin
                        byte_ok <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        framing_err <= 1'b1;
                        state       <= S_WAIT;
                    end
                end else timer <= timer + 1'b1;
                S_WAIT: if (rx) begin
                    state   <= S_IDLE;
                    timer   <= '0;
                    bit_cnt <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_DATA && timer == T_FULL)
            shreg <= {rx, shreg[7:1]};
    end

    // Stage: message parser
    assign chan_ok  = (CHAN_FILT_EN == 1'b0) || (shreg[3:0] == CHANNEL);
    assign ev_fire  = byte_ok && !shreg[7] && rs_valid && expect_vel;
    assign ev_is_on = rs_on && (shreg[6:0] != 7'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_valid    <= 1'b0;
            rs_on       <= 1'b0;
            expect_vel  <= 1'b0;
            event_valid <= 1'b0;
            event_on    <= 1'b0;
        end else begin
            event_valid <= ev_fire;
            event_on    <= ev_fire && ev_is_on;
            if (byte_ok) begin
                if (shreg[7]) begin
                    // Real-time bytes (F8-FF) may land mid-message and must not disturb it
                    if (shreg[7:3] != 5'b11111) begin
                        rs_valid   <= (shreg[7:5] == 3'b100) && chan_ok;
                        rs_on      <= shreg[4];
                        expect_vel <= 1'b0;
                    end
                end else if (rs_valid) begin
                    expect_vel <= !expect_vel;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (byte_ok && !shreg[7] && !expect_vel)
            key_p0 <= shreg[6:0];
    end

    // Stage: held-note stack, index 0 is the most recent key
    always_comb begin
        keys_n  = keys;
        vels_n  = vels;
        count_n = count;
        hit     = 1'b0;
        hit_idx = 0;
        lim     = MAX_NOTES - 1;
        for (int i = 0; i < MAX_NOTES; i++) begin
            if (!hit && i < int'(count) && keys[i] == key_p0) begin
                hit     = 1'b1;
                hit_idx = i;
            end
        end
        if (ev_fire) begin
            if (ev_is_on) begin
                // A re-pressed key only shifts the entries above it; a new key shifts all, dropping the oldest
                lim = hit ? hit_idx : MAX_NOTES - 1;
                for (int i = 1; i < MAX_NOTES; i++) begin
                    if (i <= lim) begin
                        keys_n[i] = keys[i-1];
                        vels_n[i] = vels[i-1];
                    end
                end
                keys_n[0] = key_p0;
                vels_n[0] = shreg[6:0];
                if (!hit && count != CW'(MAX_NOTES))
                    count_n = count + 1'b1;
            end else if (hit) begin
                for (int i = 0; i < MAX_NOTES - 1; i++) begin
                    if (i >= hit_idx) begin
                        keys_n[i] = keys[i+1];
                        vels_n[i] = vels[i+1];
                    end
                end
                count_n = count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        keys <= keys_n;
        vels <= vels_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else     count <= count_n;
    end

    assign note_active = (count != '0);
    assign note_out    = note_active ? keys[0] : 7'd0;
    assign vel_out     = note_active ? vels[0] : 7'd0;
    assign held_count  = count;

endmodule

// File: tb/tb_midi_note_tracker.sv
// Bench for midi_note_tracker: serial MIDI stimulus, reference stack model and
// an event scoreboard for an unfiltered and a channel-2-filtered instance.
module tb_midi_note_tracker;
    localparam int CPB  = 16;
    localparam int MAXN = 4;
    localparam int CW   = $clog2(MAXN + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic midi_a = 1'b1;
    logic midi_f = 1'b1;

    logic [6:0]    note_a, vel_a, note_f, vel_f;
    logic          act_a, act_f, ev_a, ev_f, on_a, on_f, fe_a_sig, fe_f_sig;
    logic [CW-1:0] cnt_a, cnt_f;

    typedef struct packed {logic on; logic [6:0] note; logic [6:0] vel; logic [CW-1:0] cnt;} ev_t;
    typedef struct packed {logic [6:0] key; logic [6:0] vel;} ent_t;

    ev_t  q_a[$], q_f[$];
    ent_t m_a[$], m_f[$];
    ev_t  exp_a, exp_f;
    int   checks = 0;
    int   failures = 0;
    int   fe_a = 0;

    always #5 clk = ~clk;

    midi_note_tracker #(.CLKS_PER_BIT(CPB), .MAX_NOTES(MAXN), .CHAN_FILT_EN(1'b0), .CHANNEL(4'd0)) dut_a (
        .clk(clk), .rst(rst), .midi_in(midi_a), .note_out(note_a), .vel_out(vel_a),
        .note_active(act_a), .held_count(cnt_a), .event_valid(ev_a), .event_on(on_a),
        .framing_err(fe_a_sig));

    midi_note_tracker #(.CLKS_PER_BIT(CPB), .MAX_NOTES(MAXN), .CHAN_FILT_EN(1'b1), .CHANNEL(4'd2)) dut_f (
        .clk(clk), .rst(rst), .midi_in(midi_f), .note_out(note_f), .vel_out(vel_f),
        .note_active(act_f), .held_count(cnt_f), .event_valid(ev_f), .event_on(on_f),
        .framing_err(fe_f_sig));

    // Scoreboard: every event pulse must match the next queued expectation
    always @(negedge clk) begin
        if (ev_a) begin
            checks++;
            if (q_a.size() == 0) begin
                failures++;
                $display("FAIL ev_a_unexpected got on=%b note=%h vel=%h cnt=%0d", on_a, note_a, vel_a, cnt_a);
            end else begin
                exp_a = q_a.pop_front();
                if ({on_a, note_a, vel_a, cnt_a} !== exp_a) begin
                    failures++;
                    $display("FAIL ev_a got on=%b note=%h vel=%h cnt=%0d want on=%b note=%h vel=%h cnt=%0d",
                             on_a, note_a, vel_a, cnt_a, exp_a.on, exp_a.note, exp_a.vel, exp_a.cnt);
                end
            end
        end
        if (ev_f) begin
            checks++;
            if (q_f.size() == 0) begin
                failures++;
                $display("FAIL ev_f_unexpected got on=%b note=%h vel=%h cnt=%0d", on_f, note_f, vel_f, cnt_f);
            end else begin
                exp_f = q_f.pop_front();
                if ({on_f, note_f, vel_f, cnt_f} !== exp_f) begin
                    failures++;
                    $display("FAIL ev_f got on=%b note=%h vel=%h cnt=%0d want on=%b note=%h vel=%h cnt=%0d",
                             on_f, note_f, vel_f, cnt_f, exp_f.on, exp_f.note, exp_f.vel, exp_f.cnt);
                end
            end
        end
        if (fe_a_sig) fe_a++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic model_event(input bit f, input bit is9, input logic [6:0] key, input logic [6:0] vel);
        ent_t m[$];
        ent_t ne;
        ev_t  e;
        int   idx = -1;
        bit   on = is9 && (vel != 7'd0);
        m = f ? m_f : m_a;
        for (int i = 0; i < m.size(); i++)
            if (idx < 0 && m[i].key == key) idx = i;
        if (on) begin
            if (idx >= 0) m.delete(idx);
            else if (m.size() == MAXN) m.delete(MAXN - 1);
            ne.key = key;
            ne.vel = vel;
            m.push_front(ne);
        end else if (idx >= 0) begin
            m.delete(idx);
        end
        e.on   = on;
        e.note = (m.size() != 0) ? m[0].key : 7'd0;
        e.vel  = (m.size() != 0) ? m[0].vel : 7'd0;
        e.cnt  = CW'(m.size());
        if (f) begin m_f = m; q_f.push_back(e); end
        else   begin m_a = m; q_a.push_back(e); end
    endtask

    task automatic drive(input bit f, input logic v);
        if (f) midi_f = v;
        else   midi_a = v;
    endtask

    task automatic send_byte(input bit f, input logic [7:0] b, input bit stop_ok);
        logic [9:0] frame;
        frame = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(f, frame[i]);
            repeat (CPB) @(negedge clk);
        end
        drive(f, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_a.delete(); m_f.delete(); q_a.delete(); q_f.delete();
        fe_a = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({note_a, vel_a} !== 14'd0) begin
            failures++; $display("FAIL reset_note_vel got=%h want=0", {note_a, vel_a});
        end
        checks++;
        if ({act_a, cnt_a} !== '0) begin
            failures++; $display("FAIL reset_count got act=%b cnt=%0d want 0", act_a, cnt_a);
        end
        checks++;
        if ({ev_a, on_a, fe_a_sig, ev_f, fe_f_sig} !== 5'd0) begin
            failures++; $display("FAIL reset_pulses got=%b want=0", {ev_a, on_a, fe_a_sig, ev_f, fe_f_sig});
        end
    endtask

    task automatic test_reset_mid_byte();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        midi_a = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        midi_a = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (cnt_a !== '0) begin
            failures++; $display("FAIL t1_after_abort got cnt=%0d want=0", cnt_a);
        end
        model_event(0, 1, 7'h3C, 7'h64);
        send_byte(0, 8'h90, 1); send_byte(0, 8'h3C, 1); send_byte(0, 8'h64, 1);
        repeat (4) @(negedge clk);
        checks++;
        if ({note_a, vel_a, cnt_a} !== {7'h3C, 7'h64, 3'd1}) begin
            failures++; $display("FAIL t1_note got note=%h vel=%h cnt=%0d want 3c 64 1", note_a, vel_a, cnt_a);
        end
        checks++;
        if (q_a.size() != 0) begin
            failures++; $display("FAIL t1_pending got=%0d want=0", q_a.size());
        end
    endtask

    task automatic test_running_status();
        do_reset();
        model_event(0, 1, 7'h3C, 7'h64);
        send_byte(0, 8'h90, 1); send_byte(0, 8'h3C, 1); send_byte(0, 8'h64, 1);
        checks++;
        if (note_a !== 7'h3C) begin
            failures++; $display("FAIL t2_first got note=%h want=3c", note_a);
        end
        model_event(0, 1, 7'h40, 7'h50);
        send_byte(0, 8'h40, 1); send_byte(0, 8'h50, 1);
        checks++;
        if (note_a !== 7'h40) begin
            failures++; $display("FAIL t2_second got note=%h want=40", note_a);
        end
        model_event(0, 1, 7'h3C, 7'h00);
        send_byte(0, 8'h3C, 1); send_byte(0, 8'h00, 1);
        repeat (4) @(negedge clk);
        checks++;
        if ({note_a, cnt_a} !== {7'h40, 3'd1}) begin
            failures++; $display("FAIL t2_off got note=%h cnt=%0d want 40 1", note_a, cnt_a);
        end
        checks++;
        if (q_a.size() != 0) begin
            failures++; $display("FAIL t2_pending got=%0d want=0", q_a.size());
        end
    endtask

    task automatic test_stack_full();
        logic [6:0] k;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            k = 7'h30 + 7'(i);
            model_event(0, 1, k, 7'h20 + 7'(i));
            send_byte(0, 8'h90, 1); send_byte(0, {1'b0, k}, 1); send_byte(0, 8'h20 + 8'(i), 1);
        end
        checks++;
        if ({note_a, cnt_a} !== {7'h34, 3'd4}) begin
            failures++; $display("FAIL t3_full got note=%h cnt=%0d want 34 4", note_a, cnt_a);
        end
        model_event(0, 0, 7'h30, 7'h40);
        send_byte(0, 8'h80, 1); send_byte(0, 8'h30, 1); send_byte(0, 8'h40, 1);
        checks++;
        if (cnt_a !== 3'd4) begin
            failures++; $display("FAIL t3_off_dropped got cnt=%0d want=4", cnt_a);
        end
        model_event(0, 0, 7'h34, 7'h00);
        send_byte(0, 8'h80, 1); send_byte(0, 8'h34, 1); send_byte(0, 8'h00, 1);
        repeat (4) @(negedge clk);
        checks++;
        if ({note_a, vel_a, cnt_a} !== {7'h33, 7'h23, 3'd3}) begin
            failures++; $display("FAIL t3_off_top got note=%h vel=%h cnt=%0d want 33 23 3", note_a, vel_a, cnt_a);
        end
        checks++;
        if (q_a.size() != 0) begin
            failures++; $display("FAIL t3_pending got=%0d want=0", q_a.size());
        end
    endtask

    task automatic test_chan_filter();
        do_reset();
        send_byte(1, 8'h91, 1); send_byte(1, 8'h3C, 1); send_byte(1, 8'h64, 1);
        checks++;
        if (cnt_f !== 3'd0) begin
            failures++; $display("FAIL t4_wrong_chan got cnt=%0d want=0", cnt_f);
        end
        model_event(1, 1, 7'h3C, 7'h64);
        send_byte(1, 8'h92, 1); send_byte(1, 8'h3C, 1); send_byte(1, 8'h64, 1);
        send_byte(1, 8'hB2, 1); send_byte(1, 8'h07, 1); send_byte(1, 8'h7F, 1);
        send_byte(1, 8'h3C, 1); send_byte(1, 8'h64, 1);
        repeat (4) @(negedge clk);
        checks++;
        if ({note_f, vel_f, cnt_f} !== {7'h3C, 7'h64, 3'd1}) begin
            failures++; $display("FAIL t4_note got note=%h vel=%h cnt=%0d want 3c 64 1", note_f, vel_f, cnt_f);
        end
        checks++;
        if (q_f.size() != 0) begin
            failures++; $display("FAIL t4_pending got=%0d want=0", q_f.size());
        end
    endtask

    task automatic test_realtime();
        do_reset();
        model_event(0, 1, 7'h3C, 7'h64);
        send_byte(0, 8'h90, 1); send_byte(0, 8'hF8, 1); send_byte(0, 8'h3C, 1);
        send_byte(0, 8'hFE, 1); send_byte(0, 8'h64, 1);
        repeat (4) @(negedge clk);
        checks++;
        if ({note_a, vel_a, cnt_a} !== {7'h3C, 7'h64, 3'd1}) begin
            failures++; $display("FAIL t5_note got note=%h vel=%h cnt=%0d want 3c 64 1", note_a, vel_a, cnt_a);
        end
        checks++;
        if (q_a.size() != 0) begin
            failures++; $display("FAIL t5_pending got=%0d want=0", q_a.size());
        end
    endtask

    task automatic test_framing();
        do_reset();
        send_byte(0, 8'h90, 0);
        repeat (4) @(negedge clk);
        checks++;
        if (fe_a != 1) begin
            failures++; $display("FAIL t6_framing_count got=%0d want=1", fe_a);
        end
        model_event(0, 1, 7'h3E, 7'h70);
        send_byte(0, 8'h90, 1); send_byte(0, 8'h3E, 1); send_byte(0, 8'h70, 1);
        repeat (4) @(negedge clk);
        checks++;
        if ({note_a, vel_a, cnt_a} !== {7'h3E, 7'h70, 3'd1}) begin
            failures++; $display("FAIL t6_note got note=%h vel=%h cnt=%0d want 3e 70 1", note_a, vel_a, cnt_a);
        end
        checks++;
        if (fe_a != 1) begin
            failures++; $display("FAIL t6_framing_after got=%0d want=1", fe_a);
        end
        checks++;
        if (q_a.size() != 0) begin
            failures++; $display("FAIL t6_pending got=%0d want=0", q_a.size());
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_byte();
        test_running_status();
        test_stack_full();
        test_chan_filter();
        test_realtime();
        test_framing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
